// File: rtl/decoder_priority_3to8_ack_pkg.sv
// Shared types and helpers for the priority-encoder acknowledge decoder.
package decoder_priority_3to8_ack_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GUARD  = 2'd2
    } state_t;

    localparam logic [7:0] ALL_INACTIVE = 8'hFF;

    // The encoder presents its index active-low; recover the plain index.
    function automatic logic [2:0] code_to_idx(input logic [2:0] code_);
        return ~code_;
    endfunction

endpackage

// File: rtl/decoder_priority_3to8_ack_decoder_3to8.sv
// Combinational 3-to-8 decoder with active-low enable and active-low one-hot output.
module decoder_3to8
    import decoder_priority_3to8_ack_pkg::*;
(
    input  logic       en_,
    input  logic [2:0] idx,
    output logic [7:0] onehot_
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        onehot_ = ALL_INACTIVE;
        if (!en_) begin
            onehot_[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/decoder_priority_3to8_ack.sv
// Acknowledge side of the 8-to-3 priority encoder link: timed active-low one-hot ack
// with a guard interval, abort on enable release, and a saturating completed-ack counter.
module decoder_priority_3to8_ack
    import decoder_priority_3to8_ack_pkg::*;
#(
    parameter int ACK_CYCLES   = 4,
    parameter int GUARD_CYCLES = 2,
    parameter int COUNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_in_,
    input  logic [2:0]         code_i_,
    input  logic               group_signal_i_,
    output logic [7:0]         signal_o_,
    output logic               group_signal_o_,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [COUNT_W-1:0] ack_count_o
);

    localparam int MAX_T   = (ACK_CYCLES > GUARD_CYCLES) ? ACK_CYCLES : GUARD_CYCLES;
    localparam int TIMER_W = $clog2(MAX_T + 1);

    localparam logic [TIMER_W-1:0] ACK_LOAD   = TIMER_W'(ACK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GUARD_LOAD =
        (GUARD_CYCLES > 0) ? TIMER_W'(GUARD_CYCLES - 1) : '0;
    localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [2:0]         idx, idx_next;
    logic               count_inc;
    logic [7:0]         signal_next;

    always_comb begin
        state_next = state;
        timer_next = timer;
        idx_next   = idx;
        count_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (!enable_in_ && !group_signal_i_) begin
                    state_next = ASSERT;
                    idx_next   = code_to_idx(code_i_);
                    timer_next = ACK_LOAD;
                end
            end
            ASSERT: begin
                // Abort outranks expiry: a released enable never completes the ack.
                if (enable_in_) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == '0) begin
                    count_inc = 1'b1;
                    if (GUARD_CYCLES > 0) begin
                        state_next = GUARD;
                        timer_next = GUARD_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            GUARD: begin
                if (enable_in_ || timer == '0) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Decode from the next state so the registered line tracks state with no extra cycle.
    decoder_3to8 u_decoder_3to8 (
        .en_     (state_next != ASSERT),
        .idx     (idx_next),
        .onehot_ (signal_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            idx         <= '0;
            signal_o_   <= ALL_INACTIVE;
            ack_count_o <= '0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            idx       <= idx_next;
            signal_o_ <= signal_next;
            if (count_inc && ack_count_o != COUNT_MAX) begin
                ack_count_o <= ack_count_o + 1'b1;
            end
        end
    end

    assign group_signal_o_ = (state != ASSERT);
    assign ready_o         = (state == IDLE);
    assign busy_o          = (state == ASSERT) || (state == GUARD);
    assign done_o          = (state == ASSERT) && (timer == '0);

endmodule

// File: tb/tb_decoder_priority_3to8_ack.sv
// Scoreboard bench: two configurations driven in lockstep, expectations from an
// elapsed-time model of each acknowledge, compared every cycle by a separate monitor.
module tb_decoder_priority_3to8_ack;

    typedef struct packed {
        logic [7:0] sig;
        logic       grp;
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_in_ = 1'b1;
    logic       group_signal_i_ = 1'b1;
    logic [2:0] code_i_ = 3'b111;

    logic [7:0] sig0, sig1;
    logic       grp0, grp1, rdy0, rdy1, bsy0, bsy1, dn0, dn1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    int ack_c[2];
    int grd_c[2];
    int cw[2];
    int age[2];
    int cnt_m[2];
    int idx_m[2];

    always #5 clk = ~clk;

    decoder_priority_3to8_ack #(.ACK_CYCLES(4), .GUARD_CYCLES(2), .COUNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .enable_in_(enable_in_), .code_i_(code_i_),
        .group_signal_i_(group_signal_i_), .signal_o_(sig0), .group_signal_o_(grp0),
        .ready_o(rdy0), .busy_o(bsy0), .done_o(dn0), .ack_count_o(cnt0)
    );

    decoder_priority_3to8_ack #(.ACK_CYCLES(4), .GUARD_CYCLES(0), .COUNT_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .enable_in_(enable_in_), .code_i_(code_i_),
        .group_signal_i_(group_signal_i_), .signal_o_(sig1), .group_signal_o_(grp1),
        .ready_o(rdy1), .busy_o(bsy1), .done_o(dn1), .ack_count_o(cnt1)
    );

    task automatic check(input string name, input exp_t act, input exp_t req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // age = cycles elapsed since the ack line went low; -1 means idle.
    function automatic exp_t model_exp(input int i);
        exp_t       e;
        logic [7:0] one;
        one   = 8'd1;
        e.sig = 8'hFF;
        e.grp = 1'b1;
        e.rdy = 1'b1;
        e.bsy = 1'b0;
        e.dn  = 1'b0;
        e.cnt = 8'(cnt_m[i]);
        if (age[i] >= 0) begin
            e.rdy = 1'b0;
            e.bsy = 1'b1;
            if (age[i] < ack_c[i]) begin
                e.sig = ~(one << idx_m[i]);
                e.grp = 1'b0;
                e.dn  = (age[i] == ack_c[i] - 1);
            end
        end
        return e;
    endfunction

    task automatic model_adv(input int i, input logic r, input logic e, input logic g,
                             input logic [2:0] c);
        if (r) begin
            age[i]   = -1;
            cnt_m[i] = 0;
        end else if (age[i] < 0) begin
            if (!e && !g) begin
                age[i]   = 0;
                idx_m[i] = 7 - int'(c);
            end
        end else if (e) begin
            age[i] = -1;
        end else begin
            if (age[i] == ack_c[i] - 1 && cnt_m[i] < (1 << cw[i]) - 1) cnt_m[i]++;
            age[i]++;
            if (age[i] >= ack_c[i] + grd_c[i]) age[i] = -1;
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic g, input logic [2:0] c);
        @(posedge clk);
        #1;
        q0.push_back(model_exp(0));
        q1.push_back(model_exp(1));
        reset           = r;
        enable_in_      = e;
        group_signal_i_ = g;
        code_i_         = c;
        model_adv(0, r, e, g, c);
        model_adv(1, r, e, g, c);
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b1, 3'b111);
    endtask

    initial begin : monitor
        exp_t a;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                a = {sig0, grp0, rdy0, bsy0, dn0, cnt0};
                check($sformatf("dut0 cycle %0d", cyc), a, q0.pop_front());
            end
            if (q1.size() > 0) begin
                a = {sig1, grp1, rdy1, bsy1, dn1, 6'b0, cnt1};
                check($sformatf("dut1 cycle %0d", cyc), a, q1.pop_front());
            end
        end
    end

    initial begin : stimulus
        ack_c = '{4, 4};
        grd_c = '{2, 0};
        cw    = '{8, 2};
        age   = '{-1, -1};
        cnt_m = '{0, 0};
        idx_m = '{0, 0};

        cycle(1'b1, 1'b1, 1'b1, 3'b111);
        cycle(1'b1, 1'b1, 1'b1, 3'b111);

        // Single request, code 010 -> index 5
        cycle(1'b0, 1'b0, 1'b0, 3'b010);
        idle_cycles(9);

        // Code changes mid-ack; held request re-accepted only from idle
        cycle(1'b0, 1'b0, 1'b0, 3'b010);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0, 3'b111);
        idle_cycles(8);

        // Abort in the second asserted cycle
        cycle(1'b0, 1'b0, 1'b0, 3'b100);
        idle_cycles(1);
        cycle(1'b0, 1'b1, 1'b1, 3'b100);
        idle_cycles(4);

        // Reset mid-ack, then group inactive with enable low
        cycle(1'b0, 1'b0, 1'b0, 3'b001);
        idle_cycles(1);
        cycle(1'b1, 1'b0, 1'b0, 3'b001);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 3'b000);

        // Held request: back-to-back acks, counter saturation on the narrow instance
        for (int k = 0; k < 30; k++) cycle(1'b0, 1'b0, 1'b0, 3'b110);
        idle_cycles(8);

        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(11) == 0),
                  ($urandom_range(3) == 0), 3'($urandom_range(7)));
        end
        idle_cycles(8);

        @(negedge clk);
        @(negedge clk);
        #1;
        check_int("dut0 scoreboard drained", q0.size(), 0);
        check_int("dut1 scoreboard drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
